// File: rtl/hazard_controller.sv
// Purpose: pipeline sequencing for the 5-stage core. Inserts load-use bubbles, flushes wrong-path fetches on taken branches, and freezes the pipe during data-memory waits.
// Latency: control outputs are combinational from the current state and inputs (zero cycles). Sequencing state advances on the rising edge of i_clk.
// Backpressure: a memory wait overrides everything below reset. Branch and hazard inputs are ignored while frozen, and a pending load stall resumes afterwards.
//
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_ID_rs1/rs2, i_ID_UsesRs1/2   source operands of the ID instruction
//   i_EX_rd, i_EX_MemRead          destination and load flag of the EX instruction
//   i_EX_BranchTaken               EX resolved a taken branch/jump
//   i_MEM_DataReq/DataReady        data-memory handshake of the MEM stage
//   o_PCWrite, o_IFIDWrite         front-end register enables
//   o_IFIDFlush, o_IDEXBubble      wrong-path clear / bubble insertion
//   o_PipeFreeze                   hold back-end registers, suppress writeback
//   o_MemTimeout                   sticky memory-wait timeout flag
//   o_StallCycles                  count of cycles with o_PCWrite low
module hazard_controller #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_ID_rs1,
  input  logic [4:0]  i_ID_rs2,
  input  logic        i_ID_UsesRs1,
  input  logic        i_ID_UsesRs2,
  input  logic [4:0]  i_EX_rd,
  input  logic        i_EX_MemRead,
  input  logic        i_EX_BranchTaken,
  input  logic        i_MEM_DataReq,
  input  logic        i_MEM_DataReady,
  output logic        o_PCWrite,
  output logic        o_IFIDWrite,
  output logic        o_IFIDFlush,
  output logic        o_IDEXBubble,
  output logic        o_PipeFreeze,
  output logic        o_MemTimeout,
  output logic [31:0] o_StallCycles
);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_LOAD_STALL = 2'd1,
    S_MEM_WAIT   = 2'd2
  } state_t;

  // Remaining bubbles after the detecting cycle.
  localparam logic [1:0] LP_BCNT_INIT = 2'(LOAD_USE_BUBBLES - 1);
  localparam logic [7:0] LP_TIMEOUT   = 8'(MEM_TIMEOUT);

  state_t      r_state;
  logic        r_ret;        // 1: LOAD_STALL was interrupted by the wait
  logic [1:0]  r_bcnt;
  logic [7:0]  r_wcnt;
  logic        r_timeout;
  logic [31:0] r_stall_cnt;

  state_t      w_state_nxt;
  state_t      w_eff_state;
  logic        w_ret_nxt;
  logic [1:0]  w_bcnt_nxt;
  logic [7:0]  w_wcnt_nxt;
  logic        w_timeout_set;
  logic        w_hz;
  logic        w_mw;

  assign w_hz = i_EX_MemRead && (i_EX_rd != 5'd0) &&
                ((i_ID_UsesRs1 && (i_ID_rs1 == i_EX_rd)) ||
                 (i_ID_UsesRs2 && (i_ID_rs2 == i_EX_rd)));

  assign w_mw = i_MEM_DataReq && !i_MEM_DataReady;

  // Once the wait ends, the cycle behaves as if we were already back in the
  // saved state, so the release cycle itself can branch, stall or run.
  assign w_eff_state = (r_state == S_MEM_WAIT) ? (r_ret ? S_LOAD_STALL : S_RUN)
                                               : r_state;

  // State register and counters
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_RUN;
      r_ret       <= 1'b0;
      r_bcnt      <= 2'd0;
      r_wcnt      <= 8'd0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end
      if (!o_PCWrite) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_ret_nxt     = r_ret;
    w_bcnt_nxt    = r_bcnt;
    w_wcnt_nxt    = r_wcnt;
    w_timeout_set = 1'b0;
    if (w_mw) begin
      if (r_state == S_MEM_WAIT) begin
        w_wcnt_nxt = (r_wcnt == 8'hFF) ? r_wcnt : r_wcnt + 8'd1;
      end else begin
        w_ret_nxt   = (r_state == S_LOAD_STALL);
        w_wcnt_nxt  = 8'd1;
        w_state_nxt = S_MEM_WAIT;
      end
      // wcnt counts wait cycles including this one
      w_timeout_set = (w_wcnt_nxt == LP_TIMEOUT);
    end else begin
      w_state_nxt = w_eff_state;
      if (i_EX_BranchTaken) begin
        w_state_nxt = S_RUN;
        w_bcnt_nxt  = 2'd0;
      end else if (w_eff_state == S_LOAD_STALL) begin
        w_bcnt_nxt  = (r_bcnt == 2'd0) ? 2'd0 : r_bcnt - 2'd1;
        w_state_nxt = (r_bcnt <= 2'd1) ? S_RUN : S_LOAD_STALL;
      end else if (w_hz && (LOAD_USE_BUBBLES > 1)) begin
        w_bcnt_nxt  = LP_BCNT_INIT;
        w_state_nxt = S_LOAD_STALL;
      end
    end
  end

  // Output logic
  always_comb begin
    o_PCWrite    = 1'b1;
    o_IFIDWrite  = 1'b1;
    o_IFIDFlush  = 1'b0;
    o_IDEXBubble = 1'b0;
    o_PipeFreeze = 1'b0;
    if (!i_rst_n) begin
      o_PCWrite    = 1'b0;
      o_IFIDWrite  = 1'b0;
      o_IFIDFlush  = 1'b1;
      o_IDEXBubble = 1'b1;
    end else if (w_mw) begin
      o_PCWrite    = 1'b0;
      o_IFIDWrite  = 1'b0;
      o_PipeFreeze = 1'b1;
    end else if (i_EX_BranchTaken) begin
      o_IFIDFlush  = 1'b1;
      o_IDEXBubble = 1'b1;
    end else if ((w_eff_state == S_LOAD_STALL) || w_hz) begin
      o_PCWrite    = 1'b0;
      o_IFIDWrite  = 1'b0;
      o_IDEXBubble = 1'b1;
    end
  end

  assign o_MemTimeout  = r_timeout;
  assign o_StallCycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       uses1, uses2, ex_memrd, ex_br, dreq, drdy;

  logic        pc1, ifw1, fl1, bb1, fz1, t1;
  logic        pc2, ifw2, fl2, bb2, fz2, t2;
  logic        pc3, ifw3, fl3, bb3, fz3, t3;
  logic [31:0] s1, s2, s3;
  logic [4:0]  c1, c2, c3;

  int n_assert = 0;
  int n_fail   = 0;

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeFreeze}
  localparam logic [4:0] RUNO = 5'b11000;
  localparam logic [4:0] STL  = 5'b00010;
  localparam logic [4:0] BR   = 5'b11110;
  localparam logic [4:0] FRZ  = 5'b00001;
  localparam logic [4:0] RST  = 5'b00110;

  always #5 clk = ~clk;

  hazard_controller #(.LOAD_USE_BUBBLES(1), .MEM_TIMEOUT(255)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ID_rs1(id_rs1), .i_ID_rs2(id_rs2),
    .i_ID_UsesRs1(uses1), .i_ID_UsesRs2(uses2), .i_EX_rd(ex_rd),
    .i_EX_MemRead(ex_memrd), .i_EX_BranchTaken(ex_br), .i_MEM_DataReq(dreq),
    .i_MEM_DataReady(drdy), .o_PCWrite(pc1), .o_IFIDWrite(ifw1),
    .o_IFIDFlush(fl1), .o_IDEXBubble(bb1), .o_PipeFreeze(fz1),
    .o_MemTimeout(t1), .o_StallCycles(s1));

  hazard_controller #(.LOAD_USE_BUBBLES(2), .MEM_TIMEOUT(255)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ID_rs1(id_rs1), .i_ID_rs2(id_rs2),
    .i_ID_UsesRs1(uses1), .i_ID_UsesRs2(uses2), .i_EX_rd(ex_rd),
    .i_EX_MemRead(ex_memrd), .i_EX_BranchTaken(ex_br), .i_MEM_DataReq(dreq),
    .i_MEM_DataReady(drdy), .o_PCWrite(pc2), .o_IFIDWrite(ifw2),
    .o_IFIDFlush(fl2), .o_IDEXBubble(bb2), .o_PipeFreeze(fz2),
    .o_MemTimeout(t2), .o_StallCycles(s2));

  hazard_controller #(.LOAD_USE_BUBBLES(3), .MEM_TIMEOUT(3)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ID_rs1(id_rs1), .i_ID_rs2(id_rs2),
    .i_ID_UsesRs1(uses1), .i_ID_UsesRs2(uses2), .i_EX_rd(ex_rd),
    .i_EX_MemRead(ex_memrd), .i_EX_BranchTaken(ex_br), .i_MEM_DataReq(dreq),
    .i_MEM_DataReady(drdy), .o_PCWrite(pc3), .o_IFIDWrite(ifw3),
    .o_IFIDFlush(fl3), .o_IDEXBubble(bb3), .o_PipeFreeze(fz3),
    .o_MemTimeout(t3), .o_StallCycles(s3));

  assign c1 = {pc1, ifw1, fl1, bb1, fz1};
  assign c2 = {pc2, ifw2, fl2, bb2, fz2};
  assign c3 = {pc3, ifw3, fl3, bb3, fz3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst_n = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; uses1 = 1'b0; uses2 = 1'b0;
    ex_rd = 5'd0; ex_memrd = 1'b0; ex_br = 1'b0; dreq = 1'b0; drdy = 1'b0;
  endtask

  // lw x5 in EX, add x?, x5, x6 in ID
  task automatic load_use();
    ex_memrd = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd6;
    uses1 = 1'b1; uses2 = 1'b1;
  endtask

  // Advance one clock edge, then settle before driving the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    // Forced outputs while reset is low
    #3;
    chk("rst_ctrl_u1", 32'(c1), 32'(RST));
    chk("rst_ctrl_u3", 32'(c3), 32'(RST));
    tick();
    rst_n = 1'b1;
    #3;
    chk("post_rst_ctrl_u1", 32'(c1), 32'(RUNO));
    chk("post_rst_ctrl_u2", 32'(c2), 32'(RUNO));
    chk("post_rst_stall_u3", s3, 32'd0);
    chk("post_rst_tmo_u3", 32'(t3), 32'd0);

    // Load-use hazard: 1, 2 and 3 bubbles
    tick(); load_use(); #3;
    chk("hz_c1_u1", 32'(c1), 32'(STL));
    chk("hz_c1_u2", 32'(c2), 32'(STL));
    chk("hz_c1_u3", 32'(c3), 32'(STL));
    tick(); ex_memrd = 1'b0; ex_rd = 5'd0; #3;
    chk("hz_c2_u1", 32'(c1), 32'(RUNO));
    chk("hz_c2_u2", 32'(c2), 32'(STL));
    chk("hz_c2_u3", 32'(c3), 32'(STL));
    chk("hz_c2_stall_u1", s1, 32'd1);
    tick(); #3;
    chk("hz_c3_u2", 32'(c2), 32'(RUNO));
    chk("hz_c3_u3", 32'(c3), 32'(STL));
    tick(); #3;
    chk("hz_c4_u3", 32'(c3), 32'(RUNO));
    chk("hz_stall_u1", s1, 32'd1);
    chk("hz_stall_u2", s2, 32'd2);
    chk("hz_stall_u3", s3, 32'd3);

    // No hazard when the load targets x0 or the operand is unused
    tick(); ex_memrd = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; uses1 = 1'b1; #3;
    chk("x0_no_stall_u2", 32'(c2), 32'(RUNO));
    tick(); ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd5; uses1 = 1'b0; uses2 = 1'b0; #3;
    chk("unused_no_stall_u2", 32'(c2), 32'(RUNO));
    // Hazard through rs2 only
    tick(); ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; uses1 = 1'b1; uses2 = 1'b1; #3;
    chk("rs2_hz_u2", 32'(c2), 32'(STL));
    tick();
    do_reset();

    // Branch in the 2nd stall cycle aborts the remaining bubbles
    load_use(); #3;
    chk("br_c1_u3", 32'(c3), 32'(STL));
    tick(); ex_memrd = 1'b0; ex_rd = 5'd0; ex_br = 1'b1; #3;
    chk("br_c2_u3", 32'(c3), 32'(BR));
    chk("br_c2_u2", 32'(c2), 32'(BR));
    tick(); ex_br = 1'b0; #3;
    chk("br_c3_u3", 32'(c3), 32'(RUNO));
    chk("br_stall_u3", s3, 32'd1);
    tick();
    do_reset();

    // Freeze of 4 cycles in the middle of a 3-bubble load stall
    load_use(); #3;
    chk("fz_d1_u3", 32'(c3), 32'(STL));
    tick(); ex_memrd = 1'b0; ex_rd = 5'd0; #3;
    chk("fz_d2_u3", 32'(c3), 32'(STL));
    tick(); dreq = 1'b1; drdy = 1'b0; #3;
    chk("fz_d3_u3", 32'(c3), 32'(FRZ));
    chk("fz_d3_u1", 32'(c1), 32'(FRZ));
    tick(); ex_br = 1'b1; #3;
    chk("fz_d4_branch_ignored_u3", 32'(c3), 32'(FRZ));
    tick(); ex_br = 1'b0; #3;
    chk("fz_d5_u3", 32'(c3), 32'(FRZ));
    chk("fz_d5_tmo_u3", 32'(t3), 32'd0);
    tick(); #3;
    chk("fz_d6_u3", 32'(c3), 32'(FRZ));
    chk("fz_d6_tmo_u3", 32'(t3), 32'd1);
    tick(); drdy = 1'b1; #3;
    chk("fz_d7_resume_u3", 32'(c3), 32'(STL));
    chk("fz_d7_u1", 32'(c1), 32'(RUNO));
    chk("fz_d7_u2", 32'(c2), 32'(RUNO));
    tick(); dreq = 1'b0; drdy = 1'b0; #3;
    chk("fz_d8_u3", 32'(c3), 32'(RUNO));
    chk("fz_stall_u1", s1, 32'd5);
    chk("fz_stall_u2", s2, 32'd6);
    chk("fz_stall_u3", s3, 32'd7);
    chk("fz_tmo_sticky_u3", 32'(t3), 32'd1);
    chk("fz_tmo_u1", 32'(t1), 32'd0);

    // Reset asserted during a memory wait
    tick(); dreq = 1'b1; #3;
    chk("rw_f1_u2", 32'(c2), 32'(FRZ));
    tick(); rst_n = 1'b0; #3;
    chk("rw_f2_ctrl_u2", 32'(c2), 32'(RST));
    chk("rw_f2_tmo_u3", 32'(t3), 32'd1);
    tick(); rst_n = 1'b1; dreq = 1'b0; #3;
    chk("rw_f3_ctrl_u2", 32'(c2), 32'(RUNO));
    chk("rw_f3_ctrl_u3", 32'(c3), 32'(RUNO));
    chk("rw_f3_stall_u3", s3, 32'd0);
    chk("rw_f3_tmo_u3", 32'(t3), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
